// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file with scoreboard.
//
// NREAD combinational read ports and NWRITE write ports over ENTRIES x WIDTH
// registers. x0 is hardwired to zero and never busy. When two write ports
// target the same register in one cycle, the higher-numbered port wins. A
// per-register busy bit is set by issue and cleared by writeback. If both
// happen to the same register in one cycle, the set wins.
//
// Optional feature macro: REGFILE_BYPASS_EN. When defined, a same-cycle write
// is forwarded to matching read ports. The busy flag of a matching read port
// is masked unless that register is also being re-issued in the same cycle.
//
// Ports:
//   clk     in   clock, rising-edge state updates
//   areset  in   asynchronous active-high reset (clears data and busy bits)
//   we      in   [NWRITE]         per-port write enable
//   wa      in   [NWRITE*ADDR_W]  write addresses, port k at [k*ADDR_W +: ADDR_W]
//   wd      in   [NWRITE*WIDTH]   write data, port k at [k*WIDTH +: WIDTH]
//   ra      in   [NREAD*ADDR_W]   read addresses, same packing
//   rd      out  [NREAD*WIDTH]    read data (combinational)
//   rbusy   out  [NREAD]          busy flag of each addressed register
//   iss_v   in   issue valid
//   iss_rd  in   [ADDR_W]         destination register of the issued instruction
module regfile_mp #(
    parameter int WIDTH   = 32,
    parameter int ADDR_W  = 5,
    parameter int ENTRIES = 32,
    parameter int NREAD   = 2,
    parameter int NWRITE  = 2
) (
    input  logic                     clk,
    input  logic                     areset,
    input  logic [NWRITE-1:0]        we,
    input  logic [NWRITE*ADDR_W-1:0] wa,
    input  logic [NWRITE*WIDTH-1:0]  wd,
    input  logic [NREAD*ADDR_W-1:0]  ra,
    output logic [NREAD*WIDTH-1:0]   rd,
    output logic [NREAD-1:0]         rbusy,
    input  logic                     iss_v,
    input  logic [ADDR_W-1:0]        iss_rd
);

    logic [WIDTH-1:0]   regs [ENTRIES];
    logic [ENTRIES-1:0] busy_q;
    logic [ENTRIES-1:0] busy_d;

    // Busy next state: writeback clears first, then issue sets, so a
    // same-cycle issue of the same register leaves it busy.
    always_comb begin
        busy_d = busy_q;
        for (int k = 0; k < NWRITE; k++) begin
            if (we[k]) begin
                busy_d[wa[k*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (iss_v && (iss_rd != '0)) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Ascending port order lets the last non-blocking write (highest port) win.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                regs[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int k = 0; k < NWRITE; k++) begin
                if (we[k] && (wa[k*ADDR_W +: ADDR_W] != '0)) begin
                    regs[wa[k*ADDR_W +: ADDR_W]] <= wd[k*WIDTH +: WIDTH];
                end
            end
            busy_q <= busy_d;
        end
    end

    always_comb begin
        logic [ADDR_W-1:0] addr;
        logic [WIDTH-1:0]  val;
        logic              bsy;
`ifdef REGFILE_BYPASS_EN
        logic              wr_hit;
        logic              iss_hit;
`endif
        rd    = '0;
        rbusy = '0;
        addr  = '0;
        val   = '0;
        bsy   = 1'b0;
`ifdef REGFILE_BYPASS_EN
        wr_hit  = 1'b0;
        iss_hit = 1'b0;
`endif
        for (int j = 0; j < NREAD; j++) begin
            addr = ra[j*ADDR_W +: ADDR_W];
            val  = regs[addr];
            bsy  = busy_q[addr];
`ifdef REGFILE_BYPASS_EN
            wr_hit = 1'b0;
            for (int k = 0; k < NWRITE; k++) begin
                if (we[k] && (wa[k*ADDR_W +: ADDR_W] != '0) &&
                    (wa[k*ADDR_W +: ADDR_W] == addr)) begin
                    val    = wd[k*WIDTH +: WIDTH];
                    wr_hit = 1'b1;
                end
            end
            iss_hit = iss_v && (iss_rd == addr);
            if (wr_hit && !iss_hit) begin
                bsy = 1'b0;
            end
`endif
            // Reset hides any in-flight forwarded data as well as stored state.
            if (areset || (addr == '0)) begin
                val = '0;
                bsy = 1'b0;
            end
            rd[j*WIDTH +: WIDTH] = val;
            rbusy[j]             = bsy;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

    localparam int WIDTH  = 32;
    localparam int ADDR_W = 5;
    localparam int NREAD  = 2;
    localparam int NWRITE = 2;

    logic                     clk;
    logic                     areset;
    logic [NWRITE-1:0]        we;
    logic [NWRITE*ADDR_W-1:0] wa;
    logic [NWRITE*WIDTH-1:0]  wd;
    logic [NREAD*ADDR_W-1:0]  ra;
    logic [NREAD*WIDTH-1:0]   rd;
    logic [NREAD-1:0]         rbusy;
    logic                     iss_v;
    logic [ADDR_W-1:0]        iss_rd;

    regfile_mp #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W),
        .ENTRIES(32),
        .NREAD  (NREAD),
        .NWRITE (NWRITE)
    ) dut (
        .clk   (clk),
        .areset(areset),
        .we    (we),
        .wa    (wa),
        .wd    (wd),
        .ra    (ra),
        .rd    (rd),
        .rbusy (rbusy),
        .iss_v (iss_v),
        .iss_rd(iss_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: architectural register contents and pending producers.
    logic [31:0] m_reg [32];
    logic [31:0] m_busy;

    int checks = 0;
    int errors = 0;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        logic [31:0] r;
        if (areset || a == 5'd0) return 32'd0;
        r = m_reg[a];
`ifdef REGFILE_BYPASS_EN
        for (int k = 0; k < NWRITE; k++)
            if (we[k] && wa[k*5 +: 5] == a) r = wd[k*32 +: 32];
`endif
        return r;
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        logic b;
        if (areset || a == 5'd0) return 1'b0;
        b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
        if ((we[0] && wa[4:0] == a) || (we[1] && wa[9:5] == a))
            if (!(iss_v && iss_rd == a)) b = 1'b0;
`endif
        return b;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
        m_busy = 32'd0;
    endtask

    task automatic set_w(input int k, input logic en, input logic [4:0] a, input logic [31:0] d);
        we[k]          = en;
        wa[k*5 +: 5]   = a;
        wd[k*32 +: 32] = d;
    endtask

    task automatic idle();
        we     = '0;
        iss_v  = 1'b0;
        iss_rd = '0;
    endtask

    // One clock cycle: check both read ports mid-cycle, then advance the model
    // across the rising edge using the inputs the DUT sees at that edge.
    task automatic tick(input string tag);
        @(negedge clk);
        if (areset) model_clear();
        for (int j = 0; j < NREAD; j++) begin
            chk32($sformatf("%s rd%0d a=%0d", tag, j, ra[j*5 +: 5]), rd[j*32 +: 32],
                  exp_rd(ra[j*5 +: 5]));
            chk1($sformatf("%s rbusy%0d a=%0d", tag, j, ra[j*5 +: 5]), rbusy[j],
                 exp_busy(ra[j*5 +: 5]));
        end
        if (!areset) begin
            for (int k = 0; k < NWRITE; k++) begin
                if (we[k]) begin
                    m_busy[wa[k*5 +: 5]] = 1'b0;
                    if (wa[k*5 +: 5] != 5'd0) m_reg[wa[k*5 +: 5]] = wd[k*32 +: 32];
                end
            end
            if (iss_v && iss_rd != 5'd0) m_busy[iss_rd] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_clear();
        areset = 1'b1;
        we = '0; wa = '0; wd = '0; ra = '0; iss_v = 1'b0; iss_rd = '0;
        #1;
        tick("reset0");
        tick("reset1");
        areset = 1'b0;

        // Reset clears a written register and all busy bits.
        set_w(0, 1'b1, 5'd5, 32'hDEADBEEF);
        iss_v = 1'b1; iss_rd = 5'd6;
        ra = {5'd6, 5'd5};
        tick("wr_x5");
        idle();
        chk32("x5_before_reset", rd[31:0], 32'hDEADBEEF);
        chk1("x6_busy_before_reset", rbusy[1], 1'b1);
        areset = 1'b1;
        set_w(1, 1'b1, 5'd5, 32'h0BAD0BAD);
        tick("in_reset0");
        tick("in_reset1");
        areset = 1'b0;
        idle();
        tick("after_reset");
        chk32("x5_after_reset", rd[31:0], 32'd0);

        // x0 ignores writes and issues.
        set_w(0, 1'b1, 5'd0, 32'h12345678);
        iss_v = 1'b1; iss_rd = 5'd0;
        ra = {5'd0, 5'd0};
        tick("x0_wr");
        idle();
        tick("x0_rd");
        chk32("x0_value", rd[31:0], 32'd0);
        chk1("x0_busy", rbusy[0], 1'b0);

        // Write collision: port 1 wins.
        set_w(0, 1'b1, 5'd7, 32'h11111111);
        set_w(1, 1'b1, 5'd7, 32'h22222222);
        ra = {5'd7, 5'd7};
        tick("collide");
        idle();
        chk32("collide_x7", rd[63:32], 32'h22222222);
        tick("collide_rd");

        // Same-cycle write to a read address.
        ra = {5'd7, 5'd3};
        set_w(0, 1'b1, 5'd3, 32'hCAFEF00D);
`ifdef REGFILE_BYPASS_EN
        #1 chk32("bypass_same_cycle", rd[31:0], 32'hCAFEF00D);
`else
        #1 chk32("no_bypass_same_cycle", rd[31:0], 32'd0);
`endif
        tick("bypass");
        idle();
        chk32("x3_next_cycle", rd[31:0], 32'hCAFEF00D);

        // Scoreboard: issue, hold, write back, then same-cycle issue + write.
        ra = {5'd9, 5'd9};
        iss_v = 1'b1; iss_rd = 5'd9;
        tick("sb_issue");
        idle();
        chk1("sb_busy_after_issue", rbusy[0], 1'b1);
        tick("sb_hold");
        set_w(1, 1'b1, 5'd9, 32'h5);
        tick("sb_write");
        idle();
        chk1("sb_busy_after_write", rbusy[0], 1'b0);
        chk32("sb_x9", rd[31:0], 32'h5);
        iss_v = 1'b1; iss_rd = 5'd9;
        set_w(0, 1'b1, 5'd9, 32'h6);
        tick("sb_both");
        idle();
        chk1("sb_set_wins", rbusy[1], 1'b1);
        tick("sb_both_after");

        // Reset raised between edges aborts the pending write.
        ra = {5'd4, 5'd4};
        set_w(1, 1'b1, 5'd4, 32'hAAAA5555);
        #2 areset = 1'b1;
        tick("mid_reset");
        areset = 1'b0;
        idle();
        chk32("x4_not_written", rd[31:0], 32'd0);
        tick("mid_reset_after");

        // Randomised traffic over a narrow address window to force collisions.
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < NWRITE; k++)
                set_w(k, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 11)), $urandom);
            iss_v  = 1'($urandom_range(0, 1));
            iss_rd = 5'($urandom_range(0, 11));
            ra     = {5'($urandom_range(0, 11)), 5'($urandom_range(0, 11))};
            if ($urandom_range(0, 49) == 0) begin
                #2 areset = 1'b1;
                tick("rand_reset");
                areset = 1'b0;
            end else begin
                tick("rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
